lcd_apb_seq: RTL and testbench
==============================

Name: lcd_apb_seq

Overview:
APB master sequencer that sits directly upstream of the lcd1602 APB peripheral and drives its psel/penable/paddr/pwdata/pwrite bus.
- Accepts LCD byte requests (instruction or data) on a valid/ready stream and buffers them in a small FIFO.
- For each entry, polls the peripheral status register until not busy, then issues one APB write to the instruction or data register.
- Lets firmware-level or test traffic drive the display without hand-built APB transfers.

Parameters:
FIFO_DEPTH, 8, request FIFO entries; power of two, >=2
ADDR_W, 8, paddr width
DATA_W, 32, pwdata/prdata width
POLL_GAP, 4, idle cycles between a busy status read and the next poll; >=1
TIMEOUT, 1024, max status polls per entry before error

Ports:
pclk  in  1  clock
preset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_rs  in  1  0 = instruction byte, 1 = data byte
req_data  in  8  byte to send
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pwrite  out  1  APB write strobe
prdata  in  DATA_W  APB read data
seq_busy  out  1  FIFO non-empty or transfer in flight
seq_err  out  1  sticky timeout flag
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
- While preset=1 at a pclk edge, the following are 0 after that edge: psel, penable, pwrite, paddr, pwdata, seq_busy, seq_err, fifo_level, FIFO pointers. FSM returns to IDLE.
- req_ready is 0 during reset.
- Reset mid-transfer aborts the transfer immediately and discards FIFO contents.
- Register map, fixed and held in the package:
  - ADDR_CMD=0x00: write, pwdata[7:0]=instruction.
  - ADDR_DATA=0x04: write, pwdata[7:0]=character.
  - ADDR_STAT=0x08: read, prdata[0]=busy.
  - pwdata upper bits are 0.
- FIFO:
  - Entry = {rs, data[7:0]}.
  - req_ready = !full, registered-free (combinational from level).
  - Push on req_valid&req_ready.
  - Pop only in WR_ACCESS.
  - Push and pop in the same cycle leave level unchanged; this is allowed when full, but req_ready is still 0 when full.
- APB: no pready. Each transfer is exactly SETUP (psel=1, penable=0) followed by ACCESS (psel=1, penable=1). Address, data and pwrite are stable across both cycles.
- FSM states:
  - IDLE: if FIFO non-empty, go to RD_SETUP, clear poll count.
  - RD_SETUP: paddr=ADDR_STAT, pwrite=0; go to RD_ACCESS.
  - RD_ACCESS: sample prdata[0] at the end of this cycle.
    - If 0: go to WR_SETUP.
    - Else if poll count = TIMEOUT-1: set seq_err, pop and drop the head entry, go to IDLE.
    - Else: increment poll count, go to GAP.
  - GAP: psel=0; count POLL_GAP cycles, then go to RD_SETUP.
  - WR_SETUP: paddr = head.rs ? ADDR_DATA : ADDR_CMD, pwdata={0,head.data}, pwrite=1; go to WR_ACCESS.
  - WR_ACCESS: pop the FIFO. If the FIFO still holds data after the pop, go directly to RD_SETUP; else go to IDLE.
- Bus is idle (psel=0, penable=0) in IDLE and GAP, and outputs return to 0 there.
- Minimum latency: from a request pushed into an empty FIFO to psel rising is 2 cycles (push, then IDLE->RD_SETUP). A full, non-busy entry takes 4 bus cycles.
- seq_busy = (state!=IDLE) | (fifo_level!=0).
- seq_err stays set until preset.

Decomposition:
- Package lcd_apb_pkg:
  - ADDR_CMD, ADDR_DATA, ADDR_STAT constants.
  - STAT_BUSY_BIT.
  - state_t enum {IDLE, RD_SETUP, RD_ACCESS, GAP, WR_SETUP, WR_ACCESS}.
  - lcd_req_t struct {rs, data}.
- One sub-module: lcd_req_fifo, a sync FIFO parameterised by depth and width with push/pop/full/empty/level. The FSM and APB drive stay in the top.

Test Plan:
- Reset, then push {rs=0, 0x38} with prdata=0 -> read of 0x08, then write paddr=0x00, pwdata=0x38; seq_busy falls after 4 bus cycles.
- Push {1,0x41}; prdata[0]=1 for 3 polls, then 0 -> 4 status reads spaced by 4 idle cycles each, then one write to 0x04 with data 0x41.
- Push 9 requests back-to-back with prdata=1 held -> req_ready drops after 8 accepted, fifo_level=8; releasing busy drains all 8 in order.
- Hold prdata[0]=1 forever (TIMEOUT=1024) -> exactly 1024 reads, seq_err=1, entry dropped, next entry is processed.
- Assert preset during WR_SETUP with 3 entries queued -> the next cycle has psel=0 and fifo_level=0, and no write to 0x00/0x04 occurs.

Source files
------------

// File: rtl/lcd_apb_pkg.sv
// Shared definitions for the lcd1602 APB sequencer: register map, FSM states
// and the request payload carried through the request FIFO.
package lcd_apb_pkg;

    localparam int unsigned BYTE_W        = 8;

    // lcd1602 peripheral register map
    localparam logic [7:0]  ADDR_CMD      = 8'h00;
    localparam logic [7:0]  ADDR_DATA     = 8'h04;
    localparam logic [7:0]  ADDR_STAT     = 8'h08;
    localparam int unsigned STAT_BUSY_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        GAP,
        WR_SETUP,
        WR_ACCESS
    } state_t;

    // One queued LCD byte: rs=0 instruction, rs=1 character data
    typedef struct packed {
        logic              rs;
        logic [BYTE_W-1:0] data;
    } lcd_req_t;

    localparam int unsigned REQ_W = $bits(lcd_req_t);

endpackage

// File: rtl/lcd_apb_seq_if.sv
// Bundle of the request stream, APB master bus and status signals of the
// sequencer.
//   master : sequencer side (accepts requests, drives APB, reports status)
//   slave  : environment side (requester + APB peripheral + status observer)
interface lcd_apb_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LVL_W  = 4
);
    import lcd_apb_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rs;
    logic [BYTE_W-1:0] req_data;
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic [DATA_W-1:0] prdata;
    logic              seq_busy;
    logic              seq_err;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        input  req_valid, req_rs, req_data, prdata,
        output req_ready, psel, penable, paddr, pwdata, pwrite,
               seq_busy, seq_err, fifo_level
    );

    modport slave (
        output req_valid, req_rs, req_data, prdata,
        input  req_ready, psel, penable, paddr, pwdata, pwrite,
               seq_busy, seq_err, fifo_level
    );

endinterface

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO with occupancy count.
//   clk, rst     : clock, synchronous active-high reset (clears pointers/level)
//   push_i/din_i : write an entry (ignored when full unless popping)
//   pop_i        : drop the head entry (ignored when empty)
//   head_c       : current head entry
//   full_c/empty_c, level_o : occupancy status
module lcd_req_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 9,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    // Occupancy, qualified push/pop and pointer advance
    always_comb begin
        empty_c  = (level_q == '0);
        full_c   = (level_q == LW'(DEPTH));
        pop_ok   = pop_i && !empty_c;
        push_ok  = push_i && (!full_c || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        head_c   = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/lcd_apb_seq.sv
// APB master sequencer for the lcd1602 peripheral. Queues LCD byte requests,
// polls the status register until not busy, then writes each byte to the
// instruction or data register.
//   pclk, preset : clock, synchronous active-high reset
//   bus.req_*    : valid/ready request stream {rs, data}
//   bus.p*       : APB master (no pready; every transfer is SETUP + ACCESS)
//   bus.seq_busy : queue non-empty or sequence in progress
//   bus.seq_err  : sticky status-poll timeout
//   bus.fifo_level : request FIFO occupancy
module lcd_apb_seq
    import lcd_apb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic           pclk,
    input  logic           preset,
    lcd_apb_seq_if.master  bus
);

    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PCNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GCNT_W = $clog2(POLL_GAP + 1);

    state_t            state_q, state_d;
    logic [PCNT_W-1:0] poll_q, poll_d;
    logic [GCNT_W-1:0] gap_q, gap_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic              req_ready_c;
    logic              push_c, pop_c;
    logic              full_c, empty_c;
    logic [LVL_W-1:0]  fifo_level;
    logic [LVL_W-1:0]  level_nxt_c;
    logic [REQ_W-1:0]  head_raw_c;
    lcd_req_t          head_c;
    logic              stat_busy_c;

    // Request acceptance: never while full or in reset
    assign req_ready_c = !full_c && !preset;
    assign push_c      = bus.req_valid && req_ready_c;
    assign head_c      = lcd_req_t'(head_raw_c);
    assign stat_busy_c = bus.prdata[STAT_BUSY_BIT];

    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (pclk),
        .rst     (preset),
        .push_i  (push_c),
        .din_i   ({bus.req_rs, bus.req_data}),
        .pop_i   (pop_c),
        .head_c  (head_raw_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level_o (fifo_level)
    );

    // Next state, poll/gap counters, FIFO pop and next bus outputs
    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        err_d     = err_q;
        pop_c     = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    state_d = RD_SETUP;
                    poll_d  = '0;
                end
            end
            RD_SETUP: state_d = RD_ACCESS;
            RD_ACCESS: begin
                if (!stat_busy_c) begin
                    state_d = WR_SETUP;
                end else if (poll_q == PCNT_W'(TIMEOUT - 1)) begin
                    // Give up on this entry and move on to the next one
                    err_d   = 1'b1;
                    pop_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    poll_d  = poll_q + PCNT_W'(1);
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GCNT_W'(POLL_GAP - 1)) begin
                    state_d = RD_SETUP;
                end else begin
                    gap_d = gap_q + GCNT_W'(1);
                end
            end
            WR_SETUP: state_d = WR_ACCESS;
            WR_ACCESS: begin
                pop_c  = 1'b1;
                poll_d = '0;
                // Chain straight into the next poll if anything remains
                if ((fifo_level > LVL_W'(1)) || push_c) begin
                    state_d = RD_SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so decode them from the next state
        unique case (state_d)
            RD_SETUP, RD_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = (state_d == RD_ACCESS);
                paddr_d   = ADDR_W'(ADDR_STAT);
            end
            WR_SETUP, WR_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = (state_d == WR_ACCESS);
                pwrite_d  = 1'b1;
                paddr_d   = head_c.rs ? ADDR_W'(ADDR_DATA) : ADDR_W'(ADDR_CMD);
                pwdata_d  = DATA_W'(head_c.data);
            end
            default: ;
        endcase

        level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
        busy_d      = (state_d != IDLE) || (level_nxt_c != '0);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            poll_q    <= '0;
            gap_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.seq_busy   = busy_q;
    assign bus.seq_err    = err_q;
    assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_lcd_apb_seq.sv
// Bench for lcd_apb_seq: directed scenarios plus a randomized phase, checked
// against a transaction-level scoreboard of expected LCD writes.
module tb_lcd_apb_seq;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned POLL_GAP   = 4;
    localparam int unsigned TIMEOUT    = 1024;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic pclk = 1'b0;
    logic preset;

    lcd_apb_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(LVL_W)) bus_if ();

    lcd_apb_seq #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .POLL_GAP   (POLL_GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_if)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Peripheral model: status busy while held or while busy budget remains
    bit              hold_busy   = 1'b0;
    int unsigned     busy_budget = 0;
    int unsigned     busy_served = 0;
    logic [DATA_W-1:0] garbage   = '0;
    assign bus_if.prdata = {garbage[DATA_W-1:1], (hold_busy || (busy_served < busy_budget))};

    // Scoreboard state
    int unsigned exp_q[$];
    int unsigned e;
    int unsigned cyc = 0;
    int unsigned last_read_cyc = 0;
    int unsigned reads_cur = 0;
    int unsigned busy_cur = 0;
    int unsigned n_reads = 0;
    int unsigned n_writes = 0;
    int unsigned n_drops = 0;
    bit          exp_err = 1'b0;
    bit          last_busy = 1'b0;
    bit          lvl_chk_en = 1'b0;
    logic              prev_psel, prev_pen, prev_wr;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;

    // Bus monitor and expected-transaction model
    always @(posedge pclk) begin
        cyc++;
        if (preset) begin
            exp_q.delete();
            reads_cur = 0;
            busy_cur  = 0;
            exp_err   = 1'b0;
        end else begin
            if (bus_if.req_valid && bus_if.req_ready)
                exp_q.push_back({23'd0, bus_if.req_rs, bus_if.req_data});
            if (bus_if.psel && bus_if.penable) begin
                check("apb_setup_before_access", 64'({prev_psel, prev_pen}), 64'(2'b10));
                check("apb_stable", 64'({prev_wr, prev_addr, prev_data}),
                      64'({bus_if.pwrite, bus_if.paddr, bus_if.pwdata}));
                if (!bus_if.pwrite) begin
                    check("rd_addr", 64'(bus_if.paddr), 64'(8'h08));
                    n_reads++;
                    if (reads_cur > 0)
                        check("poll_spacing", 64'(cyc - last_read_cyc), 64'(POLL_GAP + 2));
                    last_read_cyc = cyc;
                    reads_cur++;
                    last_busy = bus_if.prdata[0];
                    if (bus_if.prdata[0]) begin
                        busy_served <= busy_served + 1;
                        busy_cur++;
                        if (busy_cur == TIMEOUT) begin
                            if (exp_q.size() > 0) e = exp_q.pop_front();
                            exp_err   = 1'b1;
                            n_drops++;
                            reads_cur = 0;
                            busy_cur  = 0;
                        end
                    end
                    garbage <= DATA_W'($urandom);
                end else begin
                    n_writes++;
                    check("wr_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(bus_if.paddr), e[8] ? 64'(8'h04) : 64'(8'h00));
                        check("wr_data", 64'(bus_if.pwdata), 64'(e[7:0]));
                    end
                    check("wr_after_idle_status", 64'({reads_cur != 0, last_busy}), 64'(2'b10));
                    reads_cur = 0;
                    busy_cur  = 0;
                end
            end
        end
        prev_psel = bus_if.psel;
        prev_pen  = bus_if.penable;
        prev_wr   = bus_if.pwrite;
        prev_addr = bus_if.paddr;
        prev_data = bus_if.pwdata;
    end

    // FIFO occupancy must equal the number of not-yet-retired requests
    always @(negedge pclk) begin
        if (lvl_chk_en)
            check("fifo_level_model", 64'(bus_if.fifo_level), 64'(exp_q.size()));
    end

    task automatic push_req(input bit r, input bit [7:0] d, input int max_wait, output bit ok);
        bus_if.req_valid = 1'b1;
        bus_if.req_rs    = r;
        bus_if.req_data  = d;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(posedge pclk);
            ok = bus_if.req_ready;
            @(negedge pclk);
        end
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int i = 0;
        while (bus_if.seq_busy !== 1'b0 && i < max_cyc) begin
            @(negedge pclk);
            i++;
        end
        check(tag, 64'(bus_if.seq_busy), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int unsigned base_r, base_w, base_d, accepted;
        int i;

        preset           = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_rs    = 1'b0;
        bus_if.req_data  = 8'h00;

        // Reset state
        @(negedge pclk);
        check("rst_req_ready", 64'(bus_if.req_ready), 64'(0));
        check("rst_bus", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.paddr, bus_if.pwdata}), 64'(0));
        check("rst_status", 64'({bus_if.seq_busy, bus_if.seq_err, bus_if.fifo_level}), 64'(0));
        preset     = 1'b0;
        lvl_chk_en = 1'b1;

        // Instruction 0x38, peripheral ready: cycle-exact sequence
        busy_budget = busy_served;
        push_req(1'b0, 8'h38, 4, ok);
        check("t1_accepted", 64'(ok), 64'(1));
        check("t1_after_push", 64'({bus_if.psel, bus_if.seq_busy, bus_if.fifo_level}), 64'({1'b0, 1'b1, 4'd1}));
        @(negedge pclk);
        check("t1_rd_setup", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.paddr}), 64'({3'b100, 8'h08}));
        @(negedge pclk);
        check("t1_rd_access", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.paddr}), 64'({3'b110, 8'h08}));
        @(negedge pclk);
        check("t1_wr_setup", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.paddr, bus_if.pwdata}),
              64'({3'b101, 8'h00, 32'h38}));
        @(negedge pclk);
        check("t1_wr_access", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.paddr, bus_if.pwdata}),
              64'({3'b111, 8'h00, 32'h38}));
        @(negedge pclk);
        check("t1_done", 64'({bus_if.psel, bus_if.penable, bus_if.seq_busy, bus_if.fifo_level}), 64'(0));

        // Data 0x41 with three busy polls
        base_r = n_reads; base_w = n_writes;
        busy_budget = busy_served + 3;
        push_req(1'b1, 8'h41, 4, ok);
        wait_idle(200, "t2_idle");
        check("t2_reads", 64'(n_reads - base_r), 64'(4));
        check("t2_writes", 64'(n_writes - base_w), 64'(1));

        // Fill while busy: 8 accepted, 9th refused, then drain in order
        hold_busy = 1'b1;
        accepted = 0;
        bus_if.req_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus_if.req_rs   = 1'($urandom);
            bus_if.req_data = 8'($urandom);
            @(posedge pclk);
            if (bus_if.req_ready) accepted++;
            @(negedge pclk);
        end
        bus_if.req_valid = 1'b0;
        check("t3_accepted", 64'(accepted), 64'(8));
        check("t3_full", 64'({bus_if.req_ready, bus_if.fifo_level}), 64'({1'b0, 4'd8}));
        base_w = n_writes;
        hold_busy = 1'b0;
        wait_idle(600, "t3_idle");
        check("t3_writes", 64'(n_writes - base_w), 64'(8));

        // Timeout: permanent busy drops the head after exactly TIMEOUT reads
        hold_busy = 1'b1;
        base_r = n_reads; base_d = n_drops;
        push_req(1'($urandom), 8'($urandom), 4, ok);
        push_req(1'($urandom), 8'($urandom), 4, ok);
        i = 0;
        while (bus_if.seq_err !== 1'b1 && i < 8000) begin
            @(negedge pclk);
            i++;
        end
        check("t4_err", 64'(bus_if.seq_err), 64'(exp_err));
        check("t4_reads", 64'(n_reads - base_r), 64'(TIMEOUT));
        check("t4_drops", 64'(n_drops - base_d), 64'(1));
        check("t4_level", 64'(bus_if.fifo_level), 64'(1));
        base_w = n_writes;
        hold_busy = 1'b0;
        wait_idle(200, "t4_idle");
        check("t4_next_written", 64'(n_writes - base_w), 64'(1));
        check("t4_err_sticky", 64'(bus_if.seq_err), 64'(1));

        // Reset during WR_SETUP with three entries queued
        busy_budget = busy_served;
        bus_if.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_if.req_rs   = 1'($urandom);
            bus_if.req_data = 8'($urandom);
            @(negedge pclk);
        end
        bus_if.req_valid = 1'b0;
        i = 0;
        while (!(bus_if.psel === 1'b1 && bus_if.pwrite === 1'b1 && bus_if.penable === 1'b0) && i < 20) begin
            @(negedge pclk);
            i++;
        end
        check("t5_in_wr_setup", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite}), 64'(3'b101));
        check("t5_level", 64'(bus_if.fifo_level), 64'(3));
        base_w = n_writes;
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        check("t5_bus_idle", 64'({bus_if.psel, bus_if.penable, bus_if.pwrite}), 64'(0));
        check("t5_flushed", 64'({bus_if.seq_busy, bus_if.seq_err, bus_if.fifo_level}), 64'(0));
        repeat (20) @(negedge pclk);
        check("t5_no_write", 64'(n_writes - base_w), 64'(0));
        check("t5_still_idle", 64'(bus_if.seq_busy), 64'(0));

        // Randomized traffic with random busy bursts
        base_w = n_writes;
        accepted = 0;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                busy_budget = busy_served + $urandom_range(0, 3);
            push_req(1'($urandom), 8'($urandom), 2000, ok);
            if (ok) accepted++;
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end
        wait_idle(3000, "rand_idle");
        check("rand_writes", 64'(n_writes - base_w), 64'(accepted));
        check("rand_drained", 64'(exp_q.size()), 64'(0));
        check("rand_no_err", 64'(bus_if.seq_err), 64'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
